// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, baud codes, frame format and
// the baud divider table used by the receiver, the transmitter and baud_controller.
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;

    localparam logic [2:0] BAUD_300    = 3'b000;
    localparam logic [2:0] BAUD_1200   = 3'b001;
    localparam logic [2:0] BAUD_4800   = 3'b010;
    localparam logic [2:0] BAUD_9600   = 3'b011;
    localparam logic [2:0] BAUD_19200  = 3'b100;
    localparam logic [2:0] BAUD_38400  = 3'b101;
    localparam logic [2:0] BAUD_57600  = 3'b110;
    localparam logic [2:0] BAUD_115200 = 3'b111;

    localparam int DATA_BITS   = 8;
    localparam bit PARITY_EVEN = 1'b1;
    localparam int STOP_BITS   = 1;
    localparam int OVERSAMPLE  = 16;

    function automatic int baud_rate(input logic [2:0] code);
        case (code)
            BAUD_300:    return 300;
            BAUD_1200:   return 1200;
            BAUD_4800:   return 4800;
            BAUD_9600:   return 9600;
            BAUD_19200:  return 19200;
            BAUD_38400:  return 38400;
            BAUD_57600:  return 57600;
            default:     return 115200;
        endcase
    endfunction

    // Rounded clk_hz / (ticks_per_bit * baud); only called with constant arguments.
    function automatic int baud_divider(input int clk_hz, input int baud, input int ticks_per_bit);
        int den;
        den = ticks_per_bit * baud;
        return (clk_hz + den / 2) / den;
    endfunction

endpackage

// File: rtl/baud_controller.sv
// Sample-tick generator: one-clk pulse every divider period selected by baud_select.
// mode=0 gives the 16x receive sampling rate, mode=1 the 1x transmit bit rate.
module baud_controller
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [2:0] baud_select,
    input  logic       mode,
    output logic       sample_ENABLE
);

    localparam int CNT_W = $clog2(CLK_HZ / 300 + 1);

    logic [CNT_W-1:0] div;
    logic [CNT_W-1:0] rx_div;
    logic [CNT_W-1:0] tx_div;
    logic [CNT_W-1:0] cnt;

    // Loop index is constant per iteration, so each table entry folds to a literal.
    always_comb begin
        rx_div = '0;
        tx_div = '0;
        for (int i = 0; i < 8; i++) begin
            if (baud_select == 3'(i)) begin
                rx_div = CNT_W'(baud_divider(CLK_HZ, baud_rate(3'(i)), OVERSAMPLE));
                tx_div = CNT_W'(baud_divider(CLK_HZ, baud_rate(3'(i)), 1));
            end
        end
        div = mode ? tx_div : rx_div;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt           <= '0;
            sample_ENABLE <= 1'b0;
        end else if (!enable) begin
            cnt           <= '0;
            sample_ENABLE <= 1'b0;
        end else if (cnt >= div - CNT_W'(1)) begin
            cnt           <= '0;
            sample_ENABLE <= 1'b1;
        end else begin
            cnt           <= cnt + CNT_W'(1);
            sample_ENABLE <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_receiver.sv
// UART receive path: 16x oversampled 8E1 frames with parity and framing status.
// Bits are sampled mid-cell: sc=7 for the start bit, sc=15 for every later bit.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 Rx_EN,
    input  logic [2:0]           baud_select,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    logic                 rx_meta;
    logic                 rx_sync;
    logic                 tick;
    rx_state_t            state;
    logic [3:0]           sc;
    logic [2:0]           bi;
    logic [DATA_BITS-1:0] shift;
    logic                 perr;
    logic                 armed;

    baud_controller #(.CLK_HZ(CLK_HZ)) u_baud (
        .clk           (clk),
        .reset         (reset),
        .enable        (Rx_EN),
        .baud_select   (baud_select),
        .mode          (1'b0),
        .sample_ENABLE (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= RxD;
            rx_sync <= rx_meta;
        end
    end

    // armed drops after a low stop bit so a held break cannot retrigger until the line idles high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            sc        <= '0;
            bi        <= '0;
            shift     <= '0;
            perr      <= 1'b0;
            armed     <= 1'b1;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_PERROR <= 1'b0;
            Rx_FERROR <= 1'b0;
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN) begin
                state <= IDLE;
                sc    <= '0;
                bi    <= '0;
                shift <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (rx_sync) begin
                            armed <= 1'b1;
                        end else if (armed) begin
                            state <= START;
                            sc    <= '0;
                        end
                    end
                    START: begin
                        if (sc == 4'd7) begin
                            if (!rx_sync) begin
                                Rx_PERROR <= 1'b0;
                                Rx_FERROR <= 1'b0;
                                sc        <= '0;
                                bi        <= '0;
                                state     <= DATA;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            sc <= sc + 4'd1;
                        end
                    end
                    DATA: begin
                        sc <= sc + 4'd1;
                        if (sc == 4'd15) begin
                            shift <= {rx_sync, shift[DATA_BITS-1:1]};
                            bi    <= bi + 3'd1;
                            if (bi == 3'(DATA_BITS - 1))
                                state <= PARITY;
                        end
                    end
                    PARITY: begin
                        sc <= sc + 4'd1;
                        if (sc == 4'd15) begin
                            perr  <= (^shift) ^ rx_sync ^ ~PARITY_EVEN;
                            state <= STOP;
                        end
                    end
                    STOP: begin
                        sc <= sc + 4'd1;
                        if (sc == 4'd15) begin
                            Rx_DATA   <= shift;
                            Rx_PERROR <= perr;
                            Rx_FERROR <= ~rx_sync;
                            Rx_VALID  <= ~perr & rx_sync;
                            armed     <= rx_sync;
                            state     <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: good, parity-error, framing-error, glitch,
// back-to-back, mid-frame reset and mid-frame disable cases.
module tb_uart_receiver;

    localparam int CLK_HZ   = 10_000_000;
    localparam int DIV_1152 = 5;    // round(10e6 / (16*115200))
    localparam int DIV_576  = 11;   // round(10e6 / (16*57600))
    localparam int DIV_96   = 65;   // round(10e6 / (16*9600))

    logic       clk;
    logic       reset;
    logic       Rx_EN;
    logic [2:0] baud_select;
    logic       RxD;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    uart_receiver #(.CLK_HZ(CLK_HZ)) dut (
        .clk         (clk),
        .reset       (reset),
        .Rx_EN       (Rx_EN),
        .baud_select (baud_select),
        .RxD         (RxD),
        .Rx_DATA     (Rx_DATA),
        .Rx_VALID    (Rx_VALID),
        .Rx_PERROR   (Rx_PERROR),
        .Rx_FERROR   (Rx_FERROR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         vcount = 0;
    int         dbl    = 0;
    int         t_valid = 0;
    int         t_start = 0;
    bit         prev_v = 1'b0;
    logic [7:0] vq[$];

    always @(negedge clk) begin
        if (Rx_VALID) begin
            vcount  = vcount + 1;
            t_valid = cyc;
            vq.push_back(Rx_DATA);
            if (prev_v) dbl = dbl + 1;
        end
        prev_v = Rx_VALID;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bits(input logic [7:0] d, input logic pbit, input logic sbit,
                             input int div, input int nbits);
        logic [10:0] f;
        f = {sbit, pbit, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            if (i == 0) t_start = cyc;
            RxD = f[i];
            repeat (16 * div) @(negedge clk);
        end
        RxD = 1'b1;
    endtask

    int v0;
    int base;
    int lat;

    initial begin
        reset       = 1'b1;
        Rx_EN       = 1'b0;
        baud_select = 3'b111;
        RxD         = 1'b1;
        idle(4);
        check("rst_data",   Rx_DATA,   8'h00);
        check("rst_valid",  Rx_VALID,  1'b0);
        check("rst_perr",   Rx_PERROR, 1'b0);
        check("rst_ferr",   Rx_FERROR, 1'b0);
        reset = 1'b0;
        Rx_EN = 1'b1;
        idle(32 * DIV_1152);

        // good frame A5 at 115200
        v0 = vcount;
        send_bits(8'hA5, 1'b0, 1'b1, DIV_1152, 11);
        idle(16 * DIV_1152);
        check("a5_data",   Rx_DATA,   8'hA5);
        check("a5_perr",   Rx_PERROR, 1'b0);
        check("a5_ferr",   Rx_FERROR, 1'b0);
        check("a5_pulses", vcount - v0, 1);
        lat = t_valid - t_start;
        check("a5_latency_in_window", (lat >= 168 * DIV_1152 + 1) && (lat <= 169 * DIV_1152 + 4), 1'b1);

        // 07 with wrong parity bit at 9600
        baud_select = 3'b011;
        idle(16 * DIV_96);
        v0 = vcount;
        send_bits(8'h07, 1'b0, 1'b1, DIV_96, 11);
        idle(16 * DIV_96);
        check("par_data",   Rx_DATA,   8'h07);
        check("par_perr",   Rx_PERROR, 1'b1);
        check("par_ferr",   Rx_FERROR, 1'b0);
        check("par_pulses", vcount - v0, 0);

        // 3C with stop bit 0, then good 55 at 57600
        baud_select = 3'b110;
        idle(16 * DIV_576);
        v0 = vcount;
        send_bits(8'h3C, 1'b0, 1'b0, DIV_576, 11);
        idle(16 * DIV_576);
        check("frm_data",   Rx_DATA,   8'h3C);
        check("frm_ferr",   Rx_FERROR, 1'b1);
        check("frm_perr",   Rx_PERROR, 1'b0);
        check("frm_pulses", vcount - v0, 0);
        v0 = vcount;
        send_bits(8'h55, 1'b0, 1'b1, DIV_576, 11);
        idle(16 * DIV_576);
        check("rec_data",   Rx_DATA,   8'h55);
        check("rec_ferr",   Rx_FERROR, 1'b0);
        check("rec_perr",   Rx_PERROR, 1'b0);
        check("rec_pulses", vcount - v0, 1);

        // 4/16-bit glitch at 115200
        baud_select = 3'b111;
        idle(16 * DIV_1152);
        v0 = vcount;
        RxD = 1'b0;
        idle(4 * DIV_1152);
        RxD = 1'b1;
        idle(48 * DIV_1152);
        check("glt_data",   Rx_DATA,   8'h55);
        check("glt_ferr",   Rx_FERROR, 1'b0);
        check("glt_perr",   Rx_PERROR, 1'b0);
        check("glt_pulses", vcount - v0, 0);

        // three back-to-back frames at 57600
        baud_select = 3'b110;
        idle(16 * DIV_576);
        v0   = vcount;
        base = vq.size();
        send_bits(8'h01, 1'b1, 1'b1, DIV_576, 11);
        send_bits(8'h80, 1'b1, 1'b1, DIV_576, 11);
        send_bits(8'hFF, 1'b0, 1'b1, DIV_576, 11);
        idle(16 * DIV_576);
        check("b2b_pulses", vcount - v0, 3);
        check("b2b_d0", vq[base],     8'h01);
        check("b2b_d1", vq[base + 1], 8'h80);
        check("b2b_d2", vq[base + 2], 8'hFF);

        // reset at bit 4 of C3, then fresh 12
        baud_select = 3'b111;
        idle(16 * DIV_1152);
        send_bits(8'hC3, 1'b0, 1'b1, DIV_1152, 5);
        reset = 1'b1;
        #1;
        check("mrst_data",  Rx_DATA,   8'h00);
        check("mrst_valid", Rx_VALID,  1'b0);
        check("mrst_perr",  Rx_PERROR, 1'b0);
        check("mrst_ferr",  Rx_FERROR, 1'b0);
        idle(8);
        reset = 1'b0;
        idle(16 * DIV_1152);
        v0 = vcount;
        send_bits(8'h12, 1'b0, 1'b1, DIV_1152, 11);
        idle(16 * DIV_1152);
        check("post_rst_data",   Rx_DATA, 8'h12);
        check("post_rst_pulses", vcount - v0, 1);

        // same with Rx_EN dropped mid-frame
        idle(16 * DIV_1152);
        v0 = vcount;
        send_bits(8'hC3, 1'b0, 1'b1, DIV_1152, 5);
        Rx_EN = 1'b0;
        idle(16 * DIV_1152);
        send_bits(8'hC3, 1'b0, 1'b1, DIV_1152, 11);
        idle(16 * DIV_1152);
        check("dis_pulses", vcount - v0, 0);
        check("dis_data",   Rx_DATA, 8'h12);
        Rx_EN = 1'b1;
        idle(16 * DIV_1152);
        v0 = vcount;
        send_bits(8'h12, 1'b0, 1'b1, DIV_1152, 11);
        idle(16 * DIV_1152);
        check("post_en_data",   Rx_DATA,   8'h12);
        check("post_en_pulses", vcount - v0, 1);
        check("post_en_perr",   Rx_PERROR, 1'b0);

        check("no_double_valid", dbl, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
